// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the parametrised accumulator CPU: opcode map and
// controller state encoding.
package acc_cpu_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_HLT   = 4'b0000,
    OP_ADD   = 4'b0001,
    OP_XNOR  = 4'b0010,
    OP_AND   = 4'b0011,
    OP_LOAD  = 4'b0100,
    OP_STORE = 4'b0101,
    OP_SUB   = 4'b0110,
    OP_OR    = 4'b0111,
    OP_JMP   = 4'b1000,
    OP_JZ    = 4'b1001,
    OP_JC    = 4'b1010,
    OP_NOT   = 4'b1011,
    OP_SHL   = 4'b1100,
    OP_SHR   = 4'b1101,
    OP_LDI   = 4'b1110,
    OP_NOP   = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_e;

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational datapath for the accumulator CPU: computes the new AC value,
// carry-out with its write enable, and the zero flag of the result.
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] ac,
  input  logic [DATA_W-1:0] operand,
  input  logic              c_in,
  output logic [DATA_W-1:0] result,
  output logic              carry_out,
  output logic              carry_we,
  output logic              zero
);

  logic [DATA_W:0] wide_s;

  // Result and carry selection per opcode; SUB's carry is the borrow bit.
  always_comb begin
    wide_s    = {(DATA_W+1){1'b0}};
    result    = ac;
    carry_out = c_in;
    carry_we  = 1'b0;
    case (opcode)
      OP_ADD: begin
        wide_s    = {1'b0, ac} + {1'b0, operand};
        result    = wide_s[DATA_W-1:0];
        carry_out = wide_s[DATA_W];
        carry_we  = 1'b1;
      end
      OP_SUB: begin
        wide_s    = {1'b0, ac} - {1'b0, operand};
        result    = wide_s[DATA_W-1:0];
        carry_out = wide_s[DATA_W];
        carry_we  = 1'b1;
      end
      OP_SHL: begin
        result    = {ac[DATA_W-2:0], 1'b0};
        carry_out = ac[DATA_W-1];
        carry_we  = 1'b1;
      end
      OP_SHR: begin
        result    = {1'b0, ac[DATA_W-1:1]};
        carry_out = ac[0];
        carry_we  = 1'b1;
      end
      OP_AND:           result = ac & operand;
      OP_OR:            result = ac | operand;
      OP_XNOR:          result = ~(ac ^ operand);
      OP_NOT:           result = ~ac;
      OP_LOAD, OP_LDI:  result = operand;
      default:          result = ac;
    endcase
  end

  assign zero = (result == {DATA_W{1'b0}});

endmodule

// File: rtl/acc_cpu_param.sv
// Parametrised accumulator CPU with memReady stall handshake, Z/C flags,
// conditional branches and a visible halt state.
module acc_cpu_param
  import acc_cpu_pkg::*;
#(
  parameter  int ADDR_W = 4,
  localparam int DATA_W = ADDR_W + OPC_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] memoryOut,
  output logic [DATA_W-1:0] memoryIn,
  input  logic              memReady,
  output logic              halted
);

  state_e              state_r;
  logic [ADDR_W-1:0]   pc_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   ir_r;
  logic [DATA_W-1:0]   ac_r;
  logic                z_r;
  logic                c_r;
  logic                read_r;
  logic                write_r;
  logic                halted_r;

  logic [OPC_W-1:0]    opcode_s;
  logic [ADDR_W-1:0]   op_s;
  logic [DATA_W-1:0]   operand_s;
  logic [DATA_W-1:0]   alu_result_s;
  logic                alu_cout_s;
  logic                alu_cwe_s;
  logic                alu_zero_s;
  logic                taken_s;
  logic [ADDR_W-1:0]   pc_next_s;

  assign opcode_s = ir_r[DATA_W-1:ADDR_W];
  assign op_s     = ir_r[ADDR_W-1:0];

  // ALU operand: memory word during EXEC, zero-extended immediate otherwise.
  always_comb begin
    if (state_r == ST_EXEC) begin
      operand_s = memoryOut;
    end else begin
      operand_s = {{OPC_W{1'b0}}, op_s};
    end
  end

  // Branch resolution; non-branch opcodes simply fall through.
  always_comb begin
    case (opcode_s)
      OP_JMP:  taken_s = 1'b1;
      OP_JZ:   taken_s = z_r;
      OP_JC:   taken_s = c_r;
      default: taken_s = 1'b0;
    endcase
  end

  assign pc_next_s = taken_s ? op_s : pc_r;

  acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode    (opcode_s),
    .ac        (ac_r),
    .operand   (operand_s),
    .c_in      (c_r),
    .result    (alu_result_s),
    .carry_out (alu_cout_s),
    .carry_we  (alu_cwe_s),
    .zero      (alu_zero_s)
  );

  // Controller: bus outputs are registered alongside every state transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_FETCH;
      pc_r     <= {ADDR_W{1'b0}};
      addr_r   <= {ADDR_W{1'b0}};
      ir_r     <= {DATA_W{1'b0}};
      ac_r     <= {DATA_W{1'b0}};
      z_r      <= 1'b0;
      c_r      <= 1'b0;
      read_r   <= 1'b1;
      write_r  <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (memReady) begin
            ir_r    <= memoryOut;
            pc_r    <= pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            read_r  <= 1'b0;
            state_r <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          case (opcode_s)
            OP_HLT: begin
              halted_r <= 1'b1;
              state_r  <= ST_HALT;
            end
            OP_ADD, OP_XNOR, OP_AND, OP_LOAD, OP_STORE, OP_SUB, OP_OR: begin
              addr_r  <= op_s;
              read_r  <= (opcode_s != OP_STORE);
              write_r <= (opcode_s == OP_STORE);
              state_r <= ST_EXEC;
            end
            OP_NOT, OP_SHL, OP_SHR, OP_LDI: begin
              ac_r    <= alu_result_s;
              z_r     <= alu_zero_s;
              c_r     <= alu_cwe_s ? alu_cout_s : c_r;
              addr_r  <= pc_r;
              read_r  <= 1'b1;
              state_r <= ST_FETCH;
            end
            default: begin
              pc_r    <= pc_next_s;
              addr_r  <= pc_next_s;
              read_r  <= 1'b1;
              state_r <= ST_FETCH;
            end
          endcase
        end
        ST_EXEC: begin
          if (memReady) begin
            if (opcode_s != OP_STORE) begin
              ac_r <= alu_result_s;
              z_r  <= alu_zero_s;
              c_r  <= alu_cwe_s ? alu_cout_s : c_r;
            end
            addr_r  <= pc_r;
            read_r  <= 1'b1;
            write_r <= 1'b0;
            state_r <= ST_FETCH;
          end
        end
        ST_HALT: begin
          read_r  <= 1'b0;
          write_r <= 1'b0;
        end
        default: begin
          state_r <= ST_FETCH;
        end
      endcase
    end
  end

  // Reset gates the bus so an in-flight STORE cannot land during reset.
  assign read     = reset ? 1'b0 : read_r;
  assign write    = reset ? 1'b0 : write_r;
  assign address  = reset ? {ADDR_W{1'b0}} : addr_r;
  assign halted   = reset ? 1'b0 : halted_r;
  assign memoryIn = ac_r;

endmodule

// File: tb/tb_acc_cpu_param.sv
// Bench for acc_cpu_param: directed programs plus random straight-line programs
// compared against an instruction-level reference model.
module tb_acc_cpu_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        reset4 = 1'b1;
  logic        rdy4   = 1'b1;
  logic        read4, write4, halted4;
  logic [3:0]  address4;
  logic [7:0]  mout4, min4;
  logic [7:0]  mem4 [16];
  int          wr_count4 = 0;

  logic        reset6 = 1'b1;
  logic        read6, write6, halted6;
  logic [5:0]  address6;
  logic [11:0] mout6, min6;
  logic [11:0] mem6 [64];

  int ref_mem [16];
  int ref_ac, ref_z, ref_c, ref_pc, ref_cyc;

  assign mout4 = mem4[address4];
  assign mout6 = mem6[address6];

  acc_cpu_param #(.ADDR_W(4)) dut (
    .clk(clk), .reset(reset4), .read(read4), .write(write4), .address(address4),
    .memoryOut(mout4), .memoryIn(min4), .memReady(rdy4), .halted(halted4)
  );

  acc_cpu_param #(.ADDR_W(6)) dut6 (
    .clk(clk), .reset(reset6), .read(read6), .write(write6), .address(address6),
    .memoryOut(mout6), .memoryIn(min6), .memReady(1'b1), .halted(halted6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive memReady, capture any write the memories accept on this edge.
  task automatic step(input logic r);
    logic w4, w6;
    logic [3:0]  a4;
    logic [7:0]  d4;
    logic [5:0]  a6;
    logic [11:0] d6;
    rdy4 = r;
    #1;
    w4 = write4 && rdy4; a4 = address4; d4 = min4;
    w6 = write6;         a6 = address6; d6 = min6;
    @(posedge clk);
    #1;
    if (w4) begin
      mem4[a4] = d4;
      wr_count4++;
    end
    if (w6) mem6[a6] = d6;
  endtask

  task automatic clr4();
    for (int a = 0; a < 16; a++) mem4[a] = 8'h00;
  endtask

  task automatic do_reset4();
    reset4 = 1'b1;
    step(1'b1);
    step(1'b1);
    reset4 = 1'b0;
    #1;
  endtask

  task automatic run_to_halt(input bit stall, output int cyc);
    cyc = 0;
    while (!halted4 && cyc < 400) begin
      step(stall ? logic'($urandom_range(0, 3) != 0) : 1'b1);
      cyc++;
    end
    chk("halt_reached", {31'd0, halted4}, 32'd1);
  endtask

  // Instruction-level model: one loop iteration per instruction, cycles from latency rules.
  task automatic iss_run();
    int pc, ac, z, c, w, opc, op, m, s, n;
    bit done;
    pc = 0; ac = 0; z = 0; c = 0; n = 0; done = 0; ref_cyc = 0;
    while (!done && n < 200) begin
      w = ref_mem[pc]; opc = w / 16; op = w % 16;
      pc = (pc + 1) % 16; n++; ref_cyc += 2;
      if (opc >= 1 && opc <= 7) begin
        ref_cyc += 1;
        m = ref_mem[op];
        case (opc)
          1: begin s = ac + m; c = (s > 255); ac = s % 256; end
          2: ac = 255 - (ac ^ m);
          3: ac = ac & m;
          4: ac = m;
          5: ref_mem[op] = ac;
          6: begin s = ac - m; c = (s < 0); ac = (s + 256) % 256; end
          default: ac = ac | m;
        endcase
        if (opc != 5) z = (ac == 0);
      end else begin
        case (opc)
          0:  done = 1;
          8:  pc = op;
          9:  if (z != 0) pc = op;
          10: if (c != 0) pc = op;
          11: begin ac = 255 - ac; z = (ac == 0); end
          12: begin c = ac / 128; ac = (ac * 2) % 256; z = (ac == 0); end
          13: begin c = ac % 2; ac = ac / 2; z = (ac == 0); end
          14: begin ac = op; z = (ac == 0); end
          default: ;
        endcase
      end
    end
    ref_ac = ac; ref_z = z; ref_c = c; ref_pc = pc;
  endtask

  initial begin
    int cyc, wc, opc, op;
    bit stall;

    // Reset state and reset-forced outputs
    clr4();
    for (int a = 0; a < 64; a++) mem6[a] = 12'h000;
    step(1'b1);
    chk("rst_read", {31'd0, read4}, 32'd0);
    chk("rst_write", {31'd0, write4}, 32'd0);
    chk("rst_addr", {28'd0, address4}, 32'd0);
    chk("rst_halted", {31'd0, halted4}, 32'd0);
    chk("rst_ac", {24'd0, min4}, 32'd0);

    // Program 1: LOAD/XNOR/STORE/HLT
    mem4[0] = 8'h45; mem4[1] = 8'h26; mem4[2] = 8'h56; mem4[3] = 8'h00;
    mem4[5] = 8'h0A; mem4[6] = 8'h05;
    do_reset4();
    chk("p1_fetch_read", {31'd0, read4}, 32'd1);
    chk("p1_fetch_addr", {28'd0, address4}, 32'd0);
    run_to_halt(1'b0, cyc);
    chk("p1_cycles", cyc, 32'd11);
    chk("p1_m6", {24'd0, mem4[6]}, 32'hF0);
    chk("p1_ac", {24'd0, min4}, 32'hF0);
    chk("p1_z", {31'd0, dut.z_r}, 32'd0);
    chk("p1_halt_bus", {30'd0, read4, write4}, 32'd0);

    // Program 2: ADD overflow sets carry, JC taken, STORE of zero
    clr4();
    mem4[0] = 8'h48; mem4[1] = 8'h19; mem4[2] = 8'hA5; mem4[3] = 8'h00;
    mem4[5] = 8'h5A; mem4[6] = 8'h00;
    mem4[8] = 8'hFF; mem4[9] = 8'h01; mem4[10] = 8'h77;
    do_reset4();
    run_to_halt(1'b0, cyc);
    chk("p2_ac", {24'd0, min4}, 32'h00);
    chk("p2_c", {31'd0, dut.c_r}, 32'd1);
    chk("p2_z", {31'd0, dut.z_r}, 32'd1);
    chk("p2_m10", {24'd0, mem4[10]}, 32'h00);
    chk("p2_pc", {28'd0, dut.pc_r}, 32'd7);

    // Program 3: SUB to zero, JZ taken; LDI 1, JZ not taken; 0-1 borrows
    clr4();
    mem4[0] = 8'hE3; mem4[1] = 8'h6C; mem4[2] = 8'h94; mem4[3] = 8'h00;
    mem4[4] = 8'hE1; mem4[5] = 8'h93; mem4[6] = 8'hE0; mem4[7] = 8'h6D;
    mem4[8] = 8'h00; mem4[12] = 8'h03; mem4[13] = 8'h01;
    do_reset4();
    run_to_halt(1'b0, cyc);
    chk("p3_pc", {28'd0, dut.pc_r}, 32'd9);
    chk("p3_ac", {24'd0, min4}, 32'hFF);
    chk("p3_c", {31'd0, dut.c_r}, 32'd1);
    chk("p3_z", {31'd0, dut.z_r}, 32'd0);
    chk("p3_cycles", cyc, 32'd18);

    // Stalls: 3 cycles in FETCH and 2 in EXEC of a STORE
    clr4();
    mem4[0] = 8'hE7; mem4[1] = 8'h5C; mem4[2] = 8'h00; mem4[12] = 8'h33;
    do_reset4();
    step(1'b1); step(1'b1);
    wc = wr_count4;
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      chk($sformatf("stf%0d_bus", i), {26'd0, read4, write4, address4}, {26'd0, 1'b1, 1'b0, 4'd1});
    end
    step(1'b1);
    chk("st_decode_read", {31'd0, read4}, 32'd0);
    step(1'b1);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ste%0d_bus", i), {26'd0, read4, write4, address4}, {26'd0, 1'b0, 1'b1, 4'd12});
      step(1'b0);
    end
    chk("st_exec_hold", {26'd0, read4, write4, address4}, {26'd0, 1'b0, 1'b1, 4'd12});
    chk("st_no_early_wr", wr_count4 - wc, 32'd0);
    step(1'b1);
    chk("st_one_write", wr_count4 - wc, 32'd1);
    chk("st_m12", {24'd0, mem4[12]}, 32'h07);
    chk("st_back_fetch", {26'd0, read4, write4, address4}, {26'd0, 1'b1, 1'b0, 4'd2});

    // Reset during EXEC of STORE suppresses the write
    mem4[12] = 8'h33;
    do_reset4();
    step(1'b1); step(1'b1); step(1'b1); step(1'b1);
    chk("rs_exec_write", {31'd0, write4}, 32'd1);
    wc = wr_count4;
    reset4 = 1'b1;
    #1;
    chk("rs_write_gated", {31'd0, write4}, 32'd0);
    step(1'b1);
    chk("rs_no_write", wr_count4 - wc, 32'd0);
    chk("rs_m12", {24'd0, mem4[12]}, 32'h33);
    reset4 = 1'b0;
    #1;
    chk("rs_state", {dut.pc_r, min4, dut.z_r, dut.c_r, read4, address4},
        {4'd0, 8'd0, 1'b0, 1'b0, 1'b1, 4'd0});
    run_to_halt(1'b0, cyc);
    chk("rs_restart_cycles", cyc, 32'd7);
    chk("rs_restart_m12", {24'd0, mem4[12]}, 32'h07);

    // Random straight-line programs with forward branches vs the model
    for (int it = 0; it < 24; it++) begin
      stall = it[0];
      clr4();
      for (int i = 0; i < 7; i++) begin
        opc = $urandom_range(1, 15);
        if (opc >= 8 && opc <= 10) op = $urandom_range(i + 1, 7);
        else if (opc <= 7)         op = $urandom_range(10, 15);
        else                       op = $urandom_range(0, 15);
        mem4[i] = 8'((opc * 16) + op);
      end
      for (int a = 10; a < 16; a++) mem4[a] = 8'($urandom_range(0, 255));
      for (int a = 0; a < 16; a++) ref_mem[a] = int'(mem4[a]);
      iss_run();
      do_reset4();
      run_to_halt(stall, cyc);
      chk($sformatf("rnd%0d_ac", it), {24'd0, min4}, ref_ac);
      chk($sformatf("rnd%0d_zc", it), {30'd0, dut.z_r, dut.c_r}, (ref_z * 2) + ref_c);
      chk($sformatf("rnd%0d_pc", it), {28'd0, dut.pc_r}, ref_pc);
      if (!stall) chk($sformatf("rnd%0d_cycles", it), cyc, ref_cyc);
      for (int a = 10; a < 16; a++)
        chk($sformatf("rnd%0d_m%0d", it, a), {24'd0, mem4[a]}, ref_mem[a]);
    end

    // ADDR_W=6: LDI 0x2A, JMP 63, NOP at 63 wraps PC to 0
    mem6[0] = 12'h3AA; mem6[1] = 12'h23F; mem6[63] = 12'h3C0;
    reset6 = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) step(1'b1);
    chk("w6_jmp_addr", {25'd0, read6, address6}, {25'd0, 1'b1, 6'd63});
    step(1'b1);
    chk("w6_pc_wrap", {26'd0, dut6.pc_r}, 32'd0);
    step(1'b1);
    chk("w6_fetch0", {25'd0, read6, address6}, {25'd0, 1'b1, 6'd0});
    chk("w6_ac", {20'd0, min6}, 32'h02A);
    chk("w6_halted", {31'd0, halted6}, 32'd0);
    reset6 = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
